// File: rtl/mem_write_monitor_if.sv
// Data-memory write port as seen between the processor and anything observing it.
// The processor drives it (master); monitors only listen (slave).
interface mem_write_monitor_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_monitor.sv
// Self-check monitor for the data-memory write port: arm with an expected
// address/data pair, report pass on a matching write or fail after TIMEOUT RUN cycles.
module mem_write_monitor #(
    parameter logic [31:0] TIMEOUT = 32'd200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         exp_adr,
    input  logic [31:0]         exp_data,
    mem_write_monitor_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [31:0]         cycles,
    output logic [7:0]          bad_writes,
    output logic [31:0]         first_bad_adr,
    output logic [31:0]         first_bad_data,
    output logic [1:0]          dbg_state
);
    // start is a request with no acknowledge: it is taken at a rising edge only
    // while busy=0 (IDLE or DONE); busy=1 on the next cycle confirms acceptance.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] exp_adr_q, exp_adr_n;
    logic [31:0] exp_data_q, exp_data_n;
    logic [31:0] cycles_n;
    logic [7:0]  bad_n;
    logic [31:0] fb_adr_n, fb_data_n;
    logic        pass_n;
    logic        match;
    logic [31:0] cycles_inc;

    assign match      = bus.memwrite && (bus.dataadr == exp_adr_q)
                                     && (bus.writedata == exp_data_q);
    assign cycles_inc = cycles + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            exp_adr_q      <= '0;
            exp_data_q     <= '0;
            cycles         <= '0;
            bad_writes     <= '0;
            first_bad_adr  <= '0;
            first_bad_data <= '0;
            pass           <= 1'b0;
        end else begin
            state          <= state_n;
            exp_adr_q      <= exp_adr_n;
            exp_data_q     <= exp_data_n;
            cycles         <= cycles_n;
            bad_writes     <= bad_n;
            first_bad_adr  <= fb_adr_n;
            first_bad_data <= fb_data_n;
            pass           <= pass_n;
        end
    end

    always_comb begin
        state_n    = state;
        exp_adr_n  = exp_adr_q;
        exp_data_n = exp_data_q;
        cycles_n   = cycles;
        bad_n      = bad_writes;
        fb_adr_n   = first_bad_adr;
        fb_data_n  = first_bad_data;
        pass_n     = pass;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = RUN;
                    exp_adr_n  = exp_adr;
                    exp_data_n = exp_data;
                    cycles_n   = '0;
                    bad_n      = '0;
                    fb_adr_n   = '0;
                    fb_data_n  = '0;
                    pass_n     = 1'b0;
                end
            end
            RUN: begin
                cycles_n = cycles_inc;
                if (match) begin
                    // A match on the final budgeted cycle still counts as pass.
                    state_n = DONE;
                    pass_n  = 1'b1;
                end else begin
                    if (bus.memwrite) begin
                        if (bad_writes != 8'hff) bad_n = bad_writes + 8'd1;
                        if (bad_writes == 8'h00) begin
                            fb_adr_n  = bus.dataadr;
                            fb_data_n = bus.writedata;
                        end
                    end
                    if (cycles_inc == TIMEOUT) begin
                        state_n = DONE;
                        pass_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;
endmodule
